// File: rtl/beagleg_fifo_pkg.sv
// Shared record-format definitions for the beagleg byte/record fifos.
// The byte-to-record fifo and the record serializer both import this
// package so that both ends agree on word width and words per record.
package beagleg_fifo_pkg;

  // Default bits per word of a record.
  localparam int DefaultWordSize    = 8;
  // Default number of words in one record.
  localparam int DefaultRecordWords = 16;

  // Width of a whole record in bits.
  function automatic int record_bits(input int word_size, input int record_words);
    return word_size * record_words;
  endfunction

endpackage : beagleg_fifo_pkg

// File: rtl/record_serializer_if.sv
// Handshake bundle between a record producer / word consumer and the
// record serializer.
//   write_en  - offer one record (taken when full=0)
//   data_in   - record; word k occupies bits [(k+1)*WordSize-1 : k*WordSize]
//   full      - Depth records are buffered
//   read_en   - consume the current head word (taken when empty=0)
//   data_out  - current head word (0 while empty)
//   last      - data_out is the final word of its record
//   empty     - no word available
//   size      - number of unread words
// The master modport is the user side, the slave modport the serializer.
interface record_serializer_if
  import beagleg_fifo_pkg::*;
#(
  parameter int WordSize    = DefaultWordSize,
  parameter int RecordWords = DefaultRecordWords,
  parameter int Depth       = 8
) ();

  localparam int RecordSizeBits = record_bits(WordSize, RecordWords);
  localparam int StoragePosSize = $clog2(Depth * RecordWords);

  logic                      write_en;
  logic [RecordSizeBits-1:0] data_in;
  logic                      full;
  logic                      read_en;
  logic [WordSize-1:0]       data_out;
  logic                      last;
  logic                      empty;
  logic [StoragePosSize:0]   size;

  modport master (
    output write_en, data_in, read_en,
    input  full, data_out, last, empty, size
  );

  modport slave (
    input  write_en, data_in, read_en,
    output full, data_out, last, empty, size
  );

endinterface : record_serializer_if

// File: rtl/record_word_mux.sv
// Selects one word out of a record and flags the final word.
//   record - whole record, word k at bits [(k+1)*WordSize-1 : k*WordSize]
//   index  - word position inside the record
//   valid  - record is meaningful; when low both outputs are forced to 0
//   word   - selected word
//   last   - index points at word RecordWords-1
module record_word_mux
  import beagleg_fifo_pkg::*;
#(
  parameter int WordSize    = DefaultWordSize,
  parameter int RecordWords = DefaultRecordWords
) (
  input  logic [WordSize*RecordWords-1:0]  record,
  input  logic [$clog2(RecordWords)-1:0]   index,
  input  logic                             valid,
  output logic [WordSize-1:0]              word,
  output logic                             last
);

  localparam int RecordPosSize = $clog2(RecordWords);

  always_comb begin
    // NOTE: every output gets a default before any condition so no path
    // leaves it unassigned, which would otherwise infer a latch.
    word = '0;
    last = 1'b0;
    if (valid) begin
      word = record[int'(index) * WordSize +: WordSize];
      last = (index == RecordPosSize'(RecordWords - 1));
    end
  end

endmodule : record_word_mux

// File: rtl/record_serializer.sv
// Record-in / word-out fifo. Whole records are written in one cycle and
// read back one word at a time, lowest word first, with first-word
// fall-through on the output.
//   clk   - single clock, all state changes on its rising edge
//   rst_n - asynchronous active-low reset of pointers and word index
//   bus   - record_serializer_if slave modport (write_en, data_in, full,
//           read_en, data_out, last, empty, size)
// Record pointers carry one extra bit so that equal addresses can be told
// apart as either empty (same lap) or full (one lap apart).
module record_serializer
  import beagleg_fifo_pkg::*;
#(
  parameter int WordSize    = DefaultWordSize,
  parameter int RecordWords = DefaultRecordWords,
  parameter int Depth       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  record_serializer_if.slave bus
);

  localparam int RecordSizeBits = record_bits(WordSize, RecordWords);
  localparam int StorageSize    = Depth * RecordWords;
  localparam int StoragePosSize = $clog2(StorageSize);
  localparam int RecordPosSize  = $clog2(RecordWords);
  localparam int AddrSize       = $clog2(Depth);
  localparam int PtrSize        = AddrSize + 1;
  localparam int SizeBits       = StoragePosSize + 1;

  logic [RecordSizeBits-1:0] storage [Depth];

  logic [PtrSize-1:0]        write_ptr;
  logic [PtrSize-1:0]        read_ptr;
  logic [PtrSize-1:0]        ptr_diff;
  logic [RecordPosSize-1:0]  word_index;

  logic                      empty_int;
  logic                      full_int;
  logic                      write_fire;
  logic                      read_fire;
  logic [RecordSizeBits-1:0] head_record;
  logic [WordSize-1:0]       head_word;
  logic                      head_last;

  // Modular difference: number of records holding at least one unread word.
  assign ptr_diff  = write_ptr - read_ptr;
  assign empty_int = (write_ptr == read_ptr);
  assign full_int  = (ptr_diff == PtrSize'(Depth));

  // Both handshakes look only at registered state, so a read that frees
  // the last slot cannot admit a write in the same cycle, and a record
  // written into an empty buffer shows up one cycle later.
  assign write_fire = bus.write_en && !full_int;
  assign read_fire  = bus.read_en && !empty_int;

  // Storage holds data only; validity is tracked by the pointers.
  // NOTE: the record array has no reset branch on purpose - its contents
  // are never observed until written, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      storage[write_ptr[AddrSize-1:0]] <= bus.data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ptr <= '0;
    end else if (write_fire) begin
      write_ptr <= write_ptr + PtrSize'(1);
    end
  end

  // Word index walks through the head record; on its final word the
  // record is retired and the index restarts at word 0 of the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_ptr   <= '0;
      word_index <= '0;
    end else if (read_fire) begin
      if (head_last) begin
        word_index <= '0;
        read_ptr   <= read_ptr + PtrSize'(1);
      end else begin
        word_index <= word_index + RecordPosSize'(1);
      end
    end
  end

  assign head_record = storage[read_ptr[AddrSize-1:0]];

  record_word_mux #(
    .WordSize    (WordSize),
    .RecordWords (RecordWords)
  ) u_word_mux (
    .record (head_record),
    .index  (word_index),
    .valid  (!empty_int),
    .word   (head_word),
    .last   (head_last)
  );

  assign bus.data_out = head_word;
  assign bus.last     = head_last;
  assign bus.empty    = empty_int;
  assign bus.full     = full_int;
  // Records in flight times words per record, minus words already read
  // from the head record. Concatenation multiplies by RecordWords.
  assign bus.size     = {ptr_diff, {RecordPosSize{1'b0}}} - SizeBits'(word_index);

endmodule : record_serializer
